cpu_clock_sequencer: RTL and testbench
======================================

# cpu_clock_sequencer

Parametrised CPU bus clock generator that supersedes the fixed divide-by-16 generator. It drives `cpu_clk` for the 65C02 and every bus-side latch from the 63 MHz system clock. The half-period is runtime-programmable and changes glitch-free only at CPU cycle boundaries. The block emits single-`clk` rise and fall strobes, and can stretch the low (bus-active) phase for slow peripherals via a wait request.

## Interface
- `DIV_W`, 4: width of half-period value and phase counter.
- `DEFAULT_HALF`, 8: half-period in `clk` cycles after reset (8 gives the legacy divide-by-16).
- `MAX_STRETCH`, 255: maximum extra `clk` cycles a low phase may be stretched. Range 1..255.
- `clk`  in  1  63 MHz system clock.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `half_period`  in  DIV_W  requested half-period in `clk` cycles; 0 is treated as 1.
- `wait_req`  in  1  request to extend the current low phase.
- `cpu_clk`  out  1  CPU clock, registered.
- `cpu_rise`  out  1  high for the first `clk` of each high phase.
- `cpu_fall`  out  1  high for the first `clk` of each low phase.
- `stretched`  out  1  high on every `clk` spent in STRETCH.
- `timeout`  out  1  one-`clk` pulse when a stretch is force-released.
- `cycle_count`  out  16  completed CPU cycles since reset; wraps `FFFF`→`0000`.

## Operation
- States: LOW, HIGH, STRETCH. Down-counter `cnt` (DIV_W bits). Active half-period register `half_act`.
- Reset values: state LOW, `cpu_clk`=0, `cnt`=`DEFAULT_HALF`-1, `half_act`=`DEFAULT_HALF`. `cpu_rise`, `cpu_fall`, `stretched` and `timeout` are 0. `cycle_count`=0.
- LOW, `cnt`≠0: `cnt` decrements.
- LOW, `cnt`=0, `wait_req`=0: go to HIGH. `cpu_clk`←1, `cnt`←`half_act`-1, `cpu_rise` pulses on the next `clk`.
- LOW, `cnt`=0, `wait_req`=1: go to STRETCH, stretch counter←1, `cpu_clk` stays 0.
- STRETCH: go to HIGH as for LOW on the first `clk` with `wait_req`=0. If the stretch counter reaches `MAX_STRETCH` while `wait_req`=1, go to HIGH anyway and pulse `timeout`.
- HIGH, `cnt`=0: go to LOW. `cpu_clk`←0, `half_act`←max(`half_period`,1), `cnt`←that value minus 1, `cycle_count`++, `cpu_fall` pulses.
- `half_period` is sampled only at the HIGH→LOW transition. The sampled value governs both phases of the following CPU cycle, and mid-cycle changes are ignored.
- `wait_req` is sampled only at the LOW-phase end and during STRETCH; it is ignored during HIGH.
- `reset` mid-cycle or mid-stretch returns everything to reset values on the next `clk`, with no pulse emitted.

## Timing
- Period = 2·`half_act` + stretch `clk` cycles; duty is exactly 50% when there is no stretch.
- With `half_period`=1, `cpu_clk` toggles every `clk`, and `cpu_rise`/`cpu_fall` alternate every `clk`.
- First `cpu_clk` rise: `clk` cycle `DEFAULT_HALF` counting from the first cycle with `reset`=0 as cycle 0.
- `cpu_rise`/`cpu_fall` are coincident with the first `clk` in which the new `cpu_clk` level is visible.
- Write strobes qualified by `~cpu_clk` remain valid throughout STRETCH.

## Configuration
- `CPU_CLK_STRETCH_EN` defined: STRETCH state, stretch counter, `wait_req`, `stretched` and `timeout` are fully functional.
- `CPU_CLK_STRETCH_EN` undefined: STRETCH is removed and LOW always proceeds to HIGH. `wait_req` is ignored; `stretched` and `timeout` are tied to 0.

## Structure
- Shared package `cpu_clk_pkg` holds the state encoding (`ST_LOW`, `ST_HIGH`, `ST_STRETCH`) and the legacy constant `LEGACY_HALF`=8.
- Single module. No sub-module is warranted: the counter, FSM and stretch logic share the same transition conditions.

## Test plan
- Reset release, `half_period`=8, `wait_req`=0 → `cpu_clk` period 16, first rise at cycle 8, `cycle_count`=3 after 56 `clk`.
- `half_period` changed 8→3 mid-high-phase → current cycle completes at 8/8, next cycle is 3/3, no runt pulse.
- `half_period`=0 → behaves as 1; `cpu_clk` toggles every `clk`, with a `cpu_rise` or `cpu_fall` pulse on every cycle.
- `wait_req` held for 5 `clk` at LOW end, `half_period`=4 → low phase is 9 `clk`, `stretched` is high for 5 `clk`, no `timeout`.
- `wait_req` stuck high, `MAX_STRETCH`=10 → forced rise after 10 stretch cycles; `timeout` pulses once at that rise.
- `reset` asserted during STRETCH → next `clk`: `cpu_clk`=0, `cycle_count`=0, `stretched`=0; the restart matches the first scenario.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: shared constants for the CPU bus clock sequencer.
// Holds the phase-state encoding and the legacy divide-by-16 half-period.
package cpu_clk_pkg;

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_HIGH    = 2'd1;
    localparam logic [1:0] ST_STRETCH = 2'd2;

    // Half-period of the fixed generator this block replaces.
    localparam int LEGACY_HALF = 8;

    // Width of the stretch counter; covers MAX_STRETCH up to 255.
    localparam int STRETCH_W = 8;

endpackage

// File: rtl/cpu_clock_sequencer.sv
// cpu_clock_sequencer: programmable CPU bus clock with rise/fall strobes.
// The half-period is latched only when the CPU clock falls, so a new value
// takes effect at a cycle boundary and never produces a runt phase.
// Optional feature macro: CPU_CLK_STRETCH_EN enables wait-request stretching
// of the low phase, with a forced release after MAX_STRETCH extra clocks.
module cpu_clock_sequencer
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W        = 4,
    parameter int DEFAULT_HALF = LEGACY_HALF,
    parameter int MAX_STRETCH  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] half_period,
    input  logic             wait_req,
    output logic             cpu_clk,
    output logic             cpu_rise,
    output logic             cpu_fall,
    output logic             stretched,
    output logic             timeout,
    output logic [15:0]      cycle_count
);

    localparam logic [DIV_W-1:0] ZERO     = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1'b1);
    localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(DEFAULT_HALF);
    localparam logic [DIV_W-1:0] CNT_RST  = DIV_W'(DEFAULT_HALF - 1);

    // A requested half-period of zero runs as one clk per phase.
    function automatic logic [DIV_W-1:0] clamp_half(input logic [DIV_W-1:0] req);
        if (req == ZERO) begin
            return ONE;
        end else begin
            return req;
        end
    endfunction

    logic [1:0]       state_r,  state_nxt_s;
    logic [DIV_W-1:0] cnt_r,    cnt_nxt_s;
    logic [DIV_W-1:0] half_act_r, half_nxt_s;
    logic [DIV_W-1:0] half_req_s;
    logic             cpu_clk_r, clk_nxt_s;
    logic             rise_r,   rise_nxt_s;
    logic             fall_r,   fall_nxt_s;
    logic [15:0]      cycle_count_r, count_nxt_s;
    logic             go_high_s;

`ifdef CPU_CLK_STRETCH_EN
    localparam logic [STRETCH_W-1:0] STRETCH_ONE = STRETCH_W'(1'b1);
    localparam logic [STRETCH_W-1:0] STRETCH_MAX = STRETCH_W'(MAX_STRETCH);

    logic [STRETCH_W-1:0] stretch_cnt_r, stretch_nxt_s;
    logic                 stretched_r,   stretched_nxt_s;
    logic                 timeout_r,     timeout_nxt_s;
`else
    localparam int MAX_STRETCH_unused = MAX_STRETCH;
    logic wait_unused_s;
    assign wait_unused_s = wait_req;
`endif

    assign half_req_s = clamp_half(half_period);

    // Next-state logic: phase counting, phase transitions and strobe generation.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        half_nxt_s  = half_act_r;
        clk_nxt_s   = cpu_clk_r;
        count_nxt_s = cycle_count_r;
        fall_nxt_s  = 1'b0;
        rise_nxt_s  = 1'b0;
        go_high_s   = 1'b0;
`ifdef CPU_CLK_STRETCH_EN
        stretch_nxt_s   = stretch_cnt_r;
        stretched_nxt_s = 1'b0;
        timeout_nxt_s   = 1'b0;
`endif
        case (state_r)
            ST_LOW: begin
                if (cnt_r != ZERO) begin
                    cnt_nxt_s = cnt_r - ONE;
`ifdef CPU_CLK_STRETCH_EN
                end else if (wait_req) begin
                    state_nxt_s     = ST_STRETCH;
                    stretch_nxt_s   = STRETCH_ONE;
                    stretched_nxt_s = 1'b1;
`endif
                end else begin
                    go_high_s = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_r != ZERO) begin
                    cnt_nxt_s = cnt_r - ONE;
                end else begin
                    // Cycle boundary: the only point where half_period is taken.
                    state_nxt_s = ST_LOW;
                    clk_nxt_s   = 1'b0;
                    half_nxt_s  = half_req_s;
                    cnt_nxt_s   = half_req_s - ONE;
                    count_nxt_s = cycle_count_r + 16'd1;
                    fall_nxt_s  = 1'b1;
                end
            end
`ifdef CPU_CLK_STRETCH_EN
            ST_STRETCH: begin
                if (!wait_req) begin
                    go_high_s = 1'b1;
                end else if (stretch_cnt_r >= STRETCH_MAX) begin
                    go_high_s     = 1'b1;
                    timeout_nxt_s = 1'b1;
                end else begin
                    stretch_nxt_s   = stretch_cnt_r + STRETCH_ONE;
                    stretched_nxt_s = 1'b1;
                end
            end
`endif
            default: begin
                // Unreachable encoding: fall back to a clean low phase.
                state_nxt_s = ST_LOW;
                clk_nxt_s   = 1'b0;
                cnt_nxt_s   = half_act_r - ONE;
            end
        endcase

        if (go_high_s) begin
            state_nxt_s = ST_HIGH;
            clk_nxt_s   = 1'b1;
            cnt_nxt_s   = half_act_r - ONE;
            rise_nxt_s  = 1'b1;
        end else begin
            rise_nxt_s  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_LOW;
            cnt_r         <= CNT_RST;
            half_act_r    <= HALF_RST;
            cpu_clk_r     <= 1'b0;
            rise_r        <= 1'b0;
            fall_r        <= 1'b0;
            cycle_count_r <= 16'd0;
`ifdef CPU_CLK_STRETCH_EN
            stretch_cnt_r <= {STRETCH_W{1'b0}};
            stretched_r   <= 1'b0;
            timeout_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            half_act_r    <= half_nxt_s;
            cpu_clk_r     <= clk_nxt_s;
            rise_r        <= rise_nxt_s;
            fall_r        <= fall_nxt_s;
            cycle_count_r <= count_nxt_s;
`ifdef CPU_CLK_STRETCH_EN
            stretch_cnt_r <= stretch_nxt_s;
            stretched_r   <= stretched_nxt_s;
            timeout_r     <= timeout_nxt_s;
`endif
        end
    end

    assign cpu_clk     = cpu_clk_r;
    assign cpu_rise    = rise_r;
    assign cpu_fall    = fall_r;
    assign cycle_count = cycle_count_r;
`ifdef CPU_CLK_STRETCH_EN
    assign stretched   = stretched_r;
    assign timeout     = timeout_r;
`else
    assign stretched   = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// tb_cpu_clock_sequencer: directed bench with a phase-length reference model.
// Works with CPU_CLK_STRETCH_EN either defined or undefined.
module tb_cpu_clock_sequencer;

    localparam int DEF_HALF = 8;
    localparam int MAX_ST   = 10;
`ifdef CPU_CLK_STRETCH_EN
    localparam bit STRETCH_ON = 1'b1;
`else
    localparam bit STRETCH_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  half_period;
    logic        wait_req;
    logic        cpu_clk;
    logic        cpu_rise;
    logic        cpu_fall;
    logic        stretched;
    logic        timeout;
    logic [15:0] cycle_count;

    cpu_clock_sequencer #(
        .DIV_W        (4),
        .DEFAULT_HALF (DEF_HALF),
        .MAX_STRETCH  (MAX_ST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .half_period (half_period),
        .wait_req    (wait_req),
        .cpu_clk     (cpu_clk),
        .cpu_rise    (cpu_rise),
        .cpu_fall    (cpu_fall),
        .stretched   (stretched),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the CPU clock level and how many clk remain in
    // the current phase; a phase lasts the latched half-period, and a low
    // phase may be extended one clk at a time while wait is held.
    logic        m_lvl;
    int          m_left;
    int          m_h;
    bit          m_in_str;
    int          m_sc;
    logic [15:0] m_cnt;
    logic        m_rise, m_fall, m_str, m_to;

    always @(posedge clk) begin
        m_rise <= 1'b0;
        m_fall <= 1'b0;
        m_str  <= 1'b0;
        m_to   <= 1'b0;
        if (reset) begin
            m_lvl    <= 1'b0;
            m_left   <= DEF_HALF;
            m_h      <= DEF_HALF;
            m_in_str <= 1'b0;
            m_sc     <= 0;
            m_cnt    <= 16'd0;
        end else if (m_lvl) begin
            if (m_left > 1) begin
                m_left <= m_left - 1;
            end else begin
                m_lvl  <= 1'b0;
                m_h    <= (half_period == 4'd0) ? 1 : int'(half_period);
                m_left <= (half_period == 4'd0) ? 1 : int'(half_period);
                m_cnt  <= m_cnt + 16'd1;
                m_fall <= 1'b1;
            end
        end else if (m_in_str) begin
            if (!wait_req || m_sc == MAX_ST) begin
                m_lvl    <= 1'b1;
                m_left   <= m_h;
                m_in_str <= 1'b0;
                m_rise   <= 1'b1;
                m_to     <= wait_req;
            end else begin
                m_sc  <= m_sc + 1;
                m_str <= 1'b1;
            end
        end else if (m_left > 1) begin
            m_left <= m_left - 1;
        end else if (STRETCH_ON && wait_req) begin
            m_in_str <= 1'b1;
            m_sc     <= 1;
            m_str    <= 1'b1;
        end else begin
            m_lvl  <= 1'b1;
            m_left <= m_h;
            m_rise <= 1'b1;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Measurements taken from the model's outputs, sample by sample.
    int   rel = 0;
    int   first_rise = -1;
    logic [15:0] cnt56 = 16'hFFFF;
    logic run_level = 1'b0;
    int   run_len = 0;
    int   hi_len = 0;
    int   lo_len = 0;
    int   str_total = 0;
    int   to_total = 0;

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            chk("cpu_clk",     {15'd0, cpu_clk},   {15'd0, m_lvl});
            chk("cpu_rise",    {15'd0, cpu_rise},  {15'd0, m_rise});
            chk("cpu_fall",    {15'd0, cpu_fall},  {15'd0, m_fall});
            chk("stretched",   {15'd0, stretched}, {15'd0, m_str});
            chk("timeout",     {15'd0, timeout},   {15'd0, m_to});
            chk("cycle_count", cycle_count,        m_cnt);
        end
        rel++;
        if (m_rise && first_rise < 0) first_rise = rel;
        if (rel == 56) cnt56 = m_cnt;
        if (m_lvl == run_level) begin
            run_len++;
        end else begin
            if (run_level) hi_len = run_len;
            else           lo_len = run_len;
            run_level = m_lvl;
            run_len   = 1;
        end
        str_total += int'(m_str);
        to_total  += int'(m_to);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pulse(input bit want_rise, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = want_rise ? m_rise : m_fall;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no pulse within 300 clk", nm);
        end
    endtask

    initial begin
        int pulses;
        reset = 1'b1; half_period = 4'd8; wait_req = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_cpu_clk", {15'd0, cpu_clk}, 16'd0);
        chk("rst_count",   cycle_count,      16'd0);

        // Scenario 1: legacy divide-by-16 after reset release.
        reset = 1'b0; rel = 0; first_rise = -1;
        ticks(60);
        chk("first_rise_cycle", first_rise[15:0], 16'd8);
        chk("count_at_56",      cnt56,            16'd3);
        chk("div16_high_len",   hi_len[15:0],     16'd8);
        chk("div16_low_len",    lo_len[15:0],     16'd8);

        // Scenario 2: change 8 -> 3 in the middle of a high phase.
        half_period = 4'd3;
        wait_pulse(1'b0, "s2_fall_a");
        chk("s2_old_high_len", hi_len[15:0], 16'd8);
        wait_pulse(1'b1, "s2_rise");
        chk("s2_new_low_len",  lo_len[15:0], 16'd3);
        wait_pulse(1'b0, "s2_fall_b");
        chk("s2_new_high_len", hi_len[15:0], 16'd3);

        // Scenario 3: half_period 0 runs as 1.
        half_period = 4'd0;
        wait_pulse(1'b0, "s3_fall");
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(m_rise) + int'(m_fall);
        end
        chk("s3_pulses",   pulses[15:0], 16'd8);
        chk("s3_high_len", hi_len[15:0], 16'd1);
        chk("s3_low_len",  lo_len[15:0], 16'd1);

        // Scenario 4: wait held for 5 clk at the end of a 4-clk low phase.
        half_period = 4'd4;
        wait_pulse(1'b0, "s4_fall");
        ticks(3);
        str_total = 0; to_total = 0;
        wait_req = 1'b1;
        ticks(5);
        wait_req = 1'b0;
        wait_pulse(1'b1, "s4_rise");
        chk("s4_low_len",   lo_len[15:0],    STRETCH_ON ? 16'd9 : 16'd4);
        chk("s4_stretched", str_total[15:0], STRETCH_ON ? 16'd5 : 16'd0);
        chk("s4_timeout",   to_total[15:0],  16'd0);

        // Scenario 5: wait stuck high, forced release after MAX_STRETCH.
        wait_pulse(1'b0, "s5_fall");
        ticks(3);
        str_total = 0; to_total = 0;
        wait_req = 1'b1;
        wait_pulse(1'b1, "s5_rise");
        chk("s5_timeout_at_rise", {15'd0, m_to}, STRETCH_ON ? 16'd1 : 16'd0);
        chk("s5_low_len",   lo_len[15:0],    STRETCH_ON ? 16'd14 : 16'd4);
        chk("s5_stretched", str_total[15:0], STRETCH_ON ? 16'd10 : 16'd0);
        chk("s5_timeouts",  to_total[15:0],  STRETCH_ON ? 16'd1 : 16'd0);

        // Scenario 6: reset while stretching, then the legacy restart.
        wait_pulse(1'b0, "s6_fall");
        ticks(5);
        reset = 1'b1;
        tick();
        chk("s6_rst_cpu_clk",   {15'd0, cpu_clk},   16'd0);
        chk("s6_rst_count",     cycle_count,        16'd0);
        chk("s6_rst_stretched", {15'd0, stretched}, 16'd0);
        wait_req = 1'b0; half_period = 4'd8;
        reset = 1'b0; rel = 0; first_rise = -1; cnt56 = 16'hFFFF;
        ticks(60);
        chk("s6_first_rise", first_rise[15:0], 16'd8);
        chk("s6_count_at_56", cnt56,           16'd3);
        chk("s6_high_len",   hi_len[15:0],     16'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
